// File: rtl/riscv32ima_pkg.sv
// Shared definitions for the RV32IMA memory/writeback stage.
//   - Major opcode encodings (RV32 base ISA, bits [6:0])
//   - Load/store func3 encodings
//   - FSM state enum for the memory/writeback stage
//   - Helpers for the byte offset and misalignment of a sized access
package riscv32ima_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // func3[1:0] encodes the access size (00 byte, 01 half, else word).
  // The byte offset is the address aligned down to the access size.
  function automatic logic [1:0] access_off(input logic [1:0] size_code,
                                            input logic [1:0] addr_lo);
    case (size_code)
      2'b00:   access_off = addr_lo;
      2'b01:   access_off = {addr_lo[1], 1'b0};
      default: access_off = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size_code,
                                         input logic [1:0] addr_lo);
    case (size_code)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/riscv32ima_load_align.sv
// Load lane extraction and sign/zero extension (purely combinational).
// Ports:
//   rdata_i  [31:0]  raw word returned by memory
//   addr_lo_i [1:0]  low bits of the effective address
//   func3_i   [2:0]  LB/LH/LW/LBU/LHU encoding
//   data_o   [31:0]  extended register value
module riscv32ima_load_align
  import riscv32ima_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [1:0]  off;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    off       = access_off(func3_i[1:0], addr_lo_i);
    byte_lane = rdata_i[{off, 3'b000} +: 8];
    half_lane = off[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (func3_i)
      F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   data_o = {24'h0, byte_lane};
      F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   data_o = {16'h0, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/riscv32ima_mem_wback.sv
// RV32IMA memory access + writeback stage.
// Accepts one ALU result per cycle; loads/stores run a valid/ready memory
// request and (for loads) wait for read data before writing back.
// Ports:
//   clk, nrst                 clock, async active-low reset
//   alu_*                     result from execute (valid/ready handshake)
//   mem_*                     memory request / load response
//   wback_pc_wen/wback_pc     single-cycle PC redirect
//   wback_reg_*               single-cycle register file write
//   misalign_err              only with RISCV32IMA_MISALIGN_CHK_EN defined:
//                             one-cycle pulse on a dropped misaligned access
//
// state | meaning
// IDLE  | ready for a new ALU result
// REQ   | memory request held until mem_ready
// WAIT  | load accepted, waiting for mem_rvalid
module riscv32ima_mem_wback
  import riscv32ima_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int OPCODE_WIDTH   = 7,
  parameter int FUNC3_WIDTH    = 3
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [OPCODE_WIDTH-1:0]   alu_opcode,
  input  logic [FUNC3_WIDTH-1:0]    alu_func3_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] alu_src_addr,
  input  logic [REG_ADDR_WIDTH-1:0] alu_dst_addr,
  input  logic [ADDR_WIDTH-1:0]     alu_mem_addr,
  input  logic [REG_DATA_WIDTH-1:0] alu_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [REG_DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic                      mem_rvalid,
  input  logic [REG_DATA_WIDTH-1:0] mem_rdata,
  output logic                      wback_pc_wen,
  output logic [ADDR_WIDTH-1:0]     wback_pc,
  output logic                      wback_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
  output logic [REG_DATA_WIDTH-1:0] wback_reg_data
`ifdef RISCV32IMA_MISALIGN_CHK_EN
  ,
  output logic                      misalign_err
`endif
);

  state_e                    state_q, state_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic [FUNC3_WIDTH-1:0]    func3_q, func3_d;
  logic [REG_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic                      pc_wen_q, pc_wen_d;
  logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
  logic                      reg_wen_q, reg_wen_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [REG_DATA_WIDTH-1:0] reg_data_q, reg_data_d;
`ifdef RISCV32IMA_MISALIGN_CHK_EN
  logic                      misalign_q, misalign_d;
`endif

  logic                      start_mem;
  logic [1:0]                store_off;
  logic [31:0]               load_data;
  logic                      unused_src;

  // Source index is informational only.
  assign unused_src = ^alu_src_addr;

  riscv32ima_load_align u_load_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .func3_i   (func3_q),
    .data_o    (load_data)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    func3_d    = func3_q;
    dst_d      = dst_q;
    pc_wen_d   = 1'b0;
    pc_d       = pc_q;
    reg_wen_d  = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    start_mem  = 1'b0;
`ifdef RISCV32IMA_MISALIGN_CHK_EN
    misalign_d = 1'b0;
`endif
    store_off  = access_off(alu_func3_opcode[1:0], alu_mem_addr[1:0]);

    case (state_q)
      ST_IDLE: begin
        if (alu_valid) begin
          case (alu_opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
              reg_wen_d  = (alu_dst_addr != '0);
              reg_addr_d = alu_dst_addr;
              reg_data_d = alu_data;
            end
            OPC_JAL, OPC_JALR: begin
              reg_wen_d  = (alu_dst_addr != '0);
              reg_addr_d = alu_dst_addr;
              reg_data_d = alu_data;
              pc_wen_d   = 1'b1;
              pc_d       = alu_mem_addr;
            end
            OPC_BRANCH: begin
              if (alu_data[0]) begin
                pc_wen_d = 1'b1;
                pc_d     = alu_mem_addr;
              end
            end
            OPC_LOAD, OPC_STORE: begin
`ifdef RISCV32IMA_MISALIGN_CHK_EN
              if (is_misaligned(alu_func3_opcode[1:0], alu_mem_addr[1:0])) begin
                misalign_d = 1'b1;
              end else begin
                start_mem = 1'b1;
              end
`else
              start_mem = 1'b1;
`endif
            end
            default: ;
          endcase

          if (start_mem) begin
            state_d = ST_REQ;
            we_d    = (alu_opcode == OPC_STORE);
            addr_d  = alu_mem_addr;
            func3_d = alu_func3_opcode;
            dst_d   = alu_dst_addr;
            wstrb_d = 4'b0000;
            wdata_d = alu_data;
            if (alu_opcode == OPC_STORE) begin
              // Data is replicated into every lane; the strobe picks the live ones.
              case (alu_func3_opcode[1:0])
                2'b00: begin
                  wstrb_d = 4'b0001 << store_off;
                  wdata_d = {4{alu_data[7:0]}};
                end
                2'b01: begin
                  wstrb_d = 4'b0011 << store_off;
                  wdata_d = {2{alu_data[15:0]}};
                end
                default: begin
                  wstrb_d = 4'b1111;
                  wdata_d = alu_data;
                end
              endcase
            end
          end
        end
      end
      ST_REQ: begin
        // A same-cycle mem_rvalid is ignored here; read data is taken in WAIT.
        if (mem_ready) begin
          state_d = we_q ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d    = ST_IDLE;
          reg_wen_d  = (dst_q != '0);
          reg_addr_d = dst_q;
          reg_data_d = load_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      func3_q    <= '0;
      dst_q      <= '0;
      pc_wen_q   <= 1'b0;
      pc_q       <= '0;
      reg_wen_q  <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
`ifdef RISCV32IMA_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      func3_q    <= func3_d;
      dst_q      <= dst_d;
      pc_wen_q   <= pc_wen_d;
      pc_q       <= pc_d;
      reg_wen_q  <= reg_wen_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
`ifdef RISCV32IMA_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign alu_ready      = (state_q == ST_IDLE);
  assign mem_valid      = (state_q == ST_REQ);
  assign mem_we         = mem_valid & we_q;
  assign mem_wstrb      = mem_valid ? wstrb_q : 4'b0000;
  assign mem_addr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata      = wdata_q;
  assign wback_pc_wen   = pc_wen_q;
  assign wback_pc       = pc_q;
  assign wback_reg_wen  = reg_wen_q;
  assign wback_reg_addr = reg_addr_q;
  assign wback_reg_data = reg_data_q;
`ifdef RISCV32IMA_MISALIGN_CHK_EN
  assign misalign_err   = misalign_q;
`endif

endmodule

// File: tb/tb_riscv32ima_mem_wback.sv
module tb_riscv32ima_mem_wback;

  // ISA encodings, written out independently of the design package.
  localparam logic [6:0] T_LOAD   = 7'h03;
  localparam logic [6:0] T_MISC   = 7'h0F;
  localparam logic [6:0] T_OPIMM  = 7'h13;
  localparam logic [6:0] T_AUIPC  = 7'h17;
  localparam logic [6:0] T_STORE  = 7'h23;
  localparam logic [6:0] T_OP     = 7'h33;
  localparam logic [6:0] T_LUI    = 7'h37;
  localparam logic [6:0] T_BRANCH = 7'h63;
  localparam logic [6:0] T_JALR   = 7'h67;
  localparam logic [6:0] T_JAL    = 7'h6F;
  localparam logic [6:0] T_SYSTEM = 7'h73;

  logic        clk = 1'b0;
  logic        nrst;
  logic        alu_valid;
  logic        alu_ready;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3_opcode;
  logic [4:0]  alu_src_addr;
  logic [4:0]  alu_dst_addr;
  logic [31:0] alu_mem_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wback_pc_wen;
  logic [31:0] wback_pc;
  logic        wback_reg_wen;
  logic [4:0]  wback_reg_addr;
  logic [31:0] wback_reg_data;
`ifdef RISCV32IMA_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  riscv32ima_mem_wback dut (
    .clk              (clk),
    .nrst             (nrst),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_opcode       (alu_opcode),
    .alu_func3_opcode (alu_func3_opcode),
    .alu_src_addr     (alu_src_addr),
    .alu_dst_addr     (alu_dst_addr),
    .alu_mem_addr     (alu_mem_addr),
    .alu_data         (alu_data),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .wback_pc_wen     (wback_pc_wen),
    .wback_pc         (wback_pc),
    .wback_reg_wen    (wback_reg_wen),
    .wback_reg_addr   (wback_reg_addr),
    .wback_reg_data   (wback_reg_data)
`ifdef RISCV32IMA_MISALIGN_CHK_EN
    ,
    .misalign_err     (misalign_err)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int acc_off(input logic [2:0] f3, input logic [31:0] addr);
    int sz = acc_size(f3);
    return (int'(addr[1:0]) / sz) * sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int sz = acc_size(f3);
    int off = acc_off(f3, addr);
    longint unsigned v = 64'(rdata) >> (8 * off);
    logic [31:0] r;
    if (sz < 4) v = v % (64'd1 << (8 * sz));
    r = v[31:0];
    if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) r = r - (32'd1 << (8 * sz));
    return r;
  endfunction

  function automatic logic writes_reg(input logic [6:0] opc);
    return opc == T_OP || opc == T_OPIMM || opc == T_LUI || opc == T_AUIPC ||
           opc == T_JAL || opc == T_JALR;
  endfunction

  // Issue one op and follow it to retirement, checking every cycle.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] dst,
                       input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                       input int rdy_dly, input int rv_dly, output logic [31:0] wb_data);
    logic is_store;
    logic exp_reg, exp_pc;
    int sz, off;
    logic [31:0] lane_mask, exp_wdata;
    logic [3:0] exp_strb;

    is_store = (opc == T_STORE);
    sz  = acc_size(f3);
    off = acc_off(f3, addr);
    wb_data = 32'h0;
    chk1("ready_before_issue", alu_ready, 1'b1);
    alu_valid = 1'b1; alu_opcode = opc; alu_func3_opcode = f3; alu_dst_addr = dst;
    alu_mem_addr = addr; alu_data = data; alu_src_addr = 5'($urandom);
    step();
    alu_valid = 1'b0;
    alu_opcode = 7'($urandom); alu_data = $urandom; alu_dst_addr = 5'($urandom);

    if (opc != T_LOAD && opc != T_STORE) begin
      exp_reg = writes_reg(opc) && dst != 5'd0;
      exp_pc  = opc == T_JAL || opc == T_JALR || (opc == T_BRANCH && data[0]);
      chk1("op_reg_wen", wback_reg_wen, exp_reg);
      chk1("op_pc_wen", wback_pc_wen, exp_pc);
      if (exp_reg) begin
        check("op_reg_addr", 32'(wback_reg_addr), 32'(dst));
        check("op_reg_data", wback_reg_data, data);
      end
      if (exp_pc) check("op_pc", wback_pc, addr);
      wb_data = wback_reg_data;
    end else begin
`ifdef RISCV32IMA_MISALIGN_CHK_EN
      if ((int'(addr[1:0]) % sz) != 0) begin
        chk1("mis_err", misalign_err, 1'b1);
        chk1("mis_mem_valid", mem_valid, 1'b0);
        chk1("mis_reg_wen", wback_reg_wen, 1'b0);
        chk1("mis_ready", alu_ready, 1'b1);
        step();
        chk1("mis_err_pulse", misalign_err, 1'b0);
        chk1("mis_mem_valid2", mem_valid, 1'b0);
        return;
      end
`endif
      exp_strb  = 4'(((1 << sz) - 1) << off);
      lane_mask = (sz == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * sz)) - 1) << (8 * off));
      exp_wdata = (sz == 4) ? data : ((data & ((32'd1 << (8 * sz)) - 1)) << (8 * off));
      for (int c = 0; c <= rdy_dly; c++) begin
        chk1("req_valid", mem_valid, 1'b1);
        chk1("req_alu_ready", alu_ready, 1'b0);
        check("req_addr", mem_addr, {addr[31:2], 2'b00});
        chk1("req_we", mem_we, is_store);
        if (is_store) begin
          check("req_wstrb", 32'(mem_wstrb), 32'(exp_strb));
          check("req_wdata", mem_wdata & lane_mask, exp_wdata);
        end
        mem_ready  = (c == rdy_dly);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
      end
      if (is_store) begin
        chk1("st_done_valid", mem_valid, 1'b0);
        chk1("st_done_ready", alu_ready, 1'b1);
        chk1("st_no_wb", wback_reg_wen, 1'b0);
      end else begin
        for (int c = 0; c <= rv_dly; c++) begin
          chk1("wait_alu_ready", alu_ready, 1'b0);
          chk1("wait_mem_valid", mem_valid, 1'b0);
          chk1("wait_no_wb", wback_reg_wen, 1'b0);
          mem_rvalid = (c == rv_dly);
          mem_rdata  = (c == rv_dly) ? rdata : $urandom;
          mem_ready  = 1'($urandom);
          step();
          mem_rvalid = 1'b0; mem_ready = 1'b0;
        end
        chk1("ld_reg_wen", wback_reg_wen, dst != 5'd0);
        chk1("ld_ready", alu_ready, 1'b1);
        if (dst != 5'd0) begin
          check("ld_reg_addr", 32'(wback_reg_addr), 32'(dst));
          check("ld_reg_data", wback_reg_data, model_load(f3, addr, rdata));
        end
        wb_data = wback_reg_data;
      end
    end
    step();
    chk1("pulse_reg_wen", wback_reg_wen, 1'b0);
    chk1("pulse_pc_wen", wback_pc_wen, 1'b0);
  endtask

  typedef struct {
    logic [6:0]  opc;
    logic [4:0]  dst;
    logic [31:0] data;
    logic [31:0] tgt;
    logic        exp_pc_wen;
    logic        exp_reg_wen;
  } vec_t;

  initial begin
    vec_t vecs[10];
    logic [6:0] nm_ops[12];
    logic [2:0] ld_f3[5];
    logic [31:0] d;

    vecs[0] = '{T_OP,     5'd5,  32'h0000_1234, 32'h0,     1'b0, 1'b1};
    vecs[1] = '{T_JAL,    5'd1,  32'h0000_0104, 32'h200,   1'b1, 1'b1};
    vecs[2] = '{T_BRANCH, 5'd3,  32'h0000_0000, 32'h300,   1'b0, 1'b0};
    vecs[3] = '{T_BRANCH, 5'd3,  32'h0000_0001, 32'h340,   1'b1, 1'b0};
    vecs[4] = '{T_LUI,    5'd0,  32'hDEAD_0000, 32'h0,     1'b0, 1'b0};
    vecs[5] = '{T_JALR,   5'd7,  32'h0000_0088, 32'h1000,  1'b1, 1'b1};
    vecs[6] = '{T_SYSTEM, 5'd9,  32'h0000_0055, 32'h44,    1'b0, 1'b0};
    vecs[7] = '{T_OPIMM,  5'd31, 32'hFFFF_FFFF, 32'h0,     1'b0, 1'b1};
    vecs[8] = '{T_MISC,   5'd2,  32'h0000_0001, 32'h80,    1'b0, 1'b0};
    vecs[9] = '{T_AUIPC,  5'd4,  32'h0000_4000, 32'h0,     1'b0, 1'b1};

    nm_ops = '{T_OP, T_OPIMM, T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH, T_BRANCH,
               T_MISC, T_SYSTEM, 7'h7F, 7'h0B};
    ld_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    nrst = 1'b0; alu_valid = 1'b0; alu_opcode = '0; alu_func3_opcode = '0;
    alu_src_addr = '0; alu_dst_addr = '0; alu_mem_addr = '0; alu_data = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset values
    step(); step();
    chk1("rst_alu_ready", alu_ready, 1'b1);
    chk1("rst_mem_valid", mem_valid, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_pc_wen", wback_pc_wen, 1'b0);
    chk1("rst_reg_wen", wback_reg_wen, 1'b0);
    check("rst_wb_pc", wback_pc, 32'h0);
    check("rst_wb_addr", 32'(wback_reg_addr), 32'h0);
    check("rst_wb_data", wback_reg_data, 32'h0);
    nrst = 1'b1;
    step();

    // Table vectors back to back at full throughput
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        chk1("tbl_pc_wen", wback_pc_wen, vecs[i-1].exp_pc_wen);
        chk1("tbl_reg_wen", wback_reg_wen, vecs[i-1].exp_reg_wen);
        if (vecs[i-1].exp_pc_wen) check("tbl_pc", wback_pc, vecs[i-1].tgt);
        if (vecs[i-1].exp_reg_wen) begin
          check("tbl_reg_addr", 32'(wback_reg_addr), 32'(vecs[i-1].dst));
          check("tbl_reg_data", wback_reg_data, vecs[i-1].data);
        end
      end
      if (i < 10) begin
        chk1("tbl_alu_ready", alu_ready, 1'b1);
        alu_valid = 1'b1; alu_opcode = vecs[i].opc; alu_dst_addr = vecs[i].dst;
        alu_data = vecs[i].data; alu_mem_addr = vecs[i].tgt; alu_func3_opcode = 3'($urandom);
      end else begin
        alu_valid = 1'b0;
      end
      step();
    end
    chk1("tbl_idle_reg_wen", wback_reg_wen, 1'b0);

    // Store byte to top lane with slow mem_ready
    issue(T_STORE, 3'b000, 5'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 3, 0, d);
    // Load sign/zero extension corner cases
    issue(T_LOAD, 3'b000, 5'd10, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1, d);
    check("lb_sign_ext", d, 32'hFFFF_FF80);
    issue(T_LOAD, 3'b101, 5'd11, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 2, 0, d);
    check("lhu_zero_ext", d, 32'h0000_BEEF);
    issue(T_LOAD, 3'b010, 5'd0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 0, 0, d);
`ifdef RISCV32IMA_MISALIGN_CHK_EN
    issue(T_LOAD, 3'b010, 5'd12, 32'h0000_3002, 32'h0, 32'h1234_5678, 0, 0, d);
`endif

    // Reset during WAIT, then a stray rvalid
    alu_valid = 1'b1; alu_opcode = T_LOAD; alu_func3_opcode = 3'b010;
    alu_dst_addr = 5'd6; alu_mem_addr = 32'h40;
    step();
    alu_valid = 1'b0;
    chk1("rw_mem_valid", mem_valid, 1'b1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk1("rw_in_wait", alu_ready, 1'b0);
    nrst = 1'b0;
    #1;
    chk1("rw_rst_ready", alu_ready, 1'b1);
    chk1("rw_rst_valid", mem_valid, 1'b0);
    step();
    nrst = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    chk1("rw_no_wb", wback_reg_wen, 1'b0);
    chk1("rw_ready", alu_ready, 1'b1);
    step();
    chk1("rw_no_wb2", wback_reg_wen, 1'b0);

    // Reset during REQ abandons the request
    alu_valid = 1'b1; alu_opcode = T_STORE; alu_func3_opcode = 3'b010;
    alu_mem_addr = 32'h80; alu_data = 32'h5555_AAAA;
    step();
    alu_valid = 1'b0;
    nrst = 1'b0;
    #1;
    chk1("rr_rst_valid", mem_valid, 1'b0);
    check("rr_rst_strb", 32'(mem_wstrb), 32'h0);
    step();
    nrst = 1'b1;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk1("rr_idle", alu_ready, 1'b1);
    chk1("rr_no_valid", mem_valid, 1'b0);

    // Randomized traffic against the model
    for (int it = 0; it < 160; it++) begin
      int k;
      logic [6:0] opc;
      logic [2:0] f3;
      k = $urandom_range(0, 9);
      if (k < 4) begin
        opc = nm_ops[$urandom_range(0, 11)];
        f3 = 3'($urandom);
      end else if (k < 7) begin
        opc = T_LOAD;
        f3 = ld_f3[$urandom_range(0, 4)];
      end else begin
        opc = T_STORE;
        f3 = 3'($urandom_range(0, 2));
      end
      issue(opc, f3, 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv32ima_mem_wback.md
RISCV32IMA_MEM_WBACK -- requirements
Module: riscv32ima_mem_wback

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH 32 (memory/PC address width), REG_ADDR_WIDTH 5 (register index width), REG_DATA_WIDTH 32 (register data width), OPCODE_WIDTH 7, FUNC3_WIDTH 3.
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
 clk  in  1  clock
 nrst  in  1  asynchronous active-low reset
 alu_valid  in  1  ALU result valid
 alu_ready  out  1  stage can accept ALU result
 alu_opcode  in  OPCODE_WIDTH  major opcode
 alu_func3_opcode  in  FUNC3_WIDTH  load/store size and sign
 alu_src_addr  in  REG_ADDR_WIDTH  source register index (informational)
 alu_dst_addr  in  REG_ADDR_WIDTH  destination register
 alu_mem_addr  in  ADDR_WIDTH  effective address / branch target
 alu_data  in  REG_DATA_WIDTH  result, store data, link value, or branch-taken flag (bit 0)
 mem_valid  out  1  memory request
 mem_ready  in  1  request accepted
 mem_we  out  1  1 = store
 mem_addr  out  ADDR_WIDTH  word-aligned address
 mem_wdata  out  REG_DATA_WIDTH  lane-shifted store data
 mem_wstrb  out  4  byte enables
 mem_rvalid  in  1  load data valid
 mem_rdata  in  REG_DATA_WIDTH  load data
 wback_pc_wen  out  1  PC redirect pulse
 wback_pc  out  ADDR_WIDTH  redirect target
 wback_reg_wen  out  1  register write pulse
 wback_reg_addr  out  REG_ADDR_WIDTH  register index
 wback_reg_data  out  REG_DATA_WIDTH  register data

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT; alu_ready = (state == IDLE).
REQ-004 Transfer occurs when alu_valid && alu_ready; in IDLE with a non-memory op, the stage SHALL stay in IDLE and accept one op per cycle.
REQ-005 OP, OP_IMM, LUI, AUIPC SHALL produce wback_reg_wen=1, wback_reg_addr=alu_dst_addr, wback_reg_data=alu_data, one cycle after transfer.
REQ-006 JAL/JALR SHALL produce the REQ-005 register write plus wback_pc_wen=1, wback_pc=alu_mem_addr in the same cycle.
REQ-007 BRANCH SHALL produce wback_pc_wen=1, wback_pc=alu_mem_addr when alu_data[0]=1; no register write.
REQ-008 MISC_MEM, SYSTEM and all other opcodes SHALL retire with no side effect.
REQ-009 LOAD/STORE SHALL go IDLE->REQ; mem_valid is held with mem_addr, mem_we, mem_wdata and mem_wstrb stable until mem_ready.
REQ-010 STORE SHALL go REQ->IDLE on mem_ready; func3 000/001/010 -> strobe 0001<<a, 0011<<a, 1111, with a = alu_mem_addr[1:0]; wdata replicated into the addressed lanes.
REQ-011 LOAD SHALL go REQ->WAIT on mem_ready, then WAIT->IDLE on mem_rvalid, writing back one cycle later; func3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, with sign/zero extension from the lane selected by alu_mem_addr[1:0].
REQ-012 wback_* SHALL be registered single-cycle pulses; wback_reg_wen SHALL be 0 whenever the destination is x0.
REQ-013 mem_rvalid outside WAIT and mem_ready outside REQ SHALL be ignored.
REQ-014 mem_ready and mem_rvalid in the same REQ cycle SHALL be treated as mem_ready only; rvalid is expected from the next cycle.

Reset
REQ-015 While nrst=0 the stage SHALL be in IDLE, with mem_valid, mem_we, mem_wstrb, wback_pc_wen and wback_reg_wen at 0, and all address/data outputs at 0.
REQ-016 Reset asserted in REQ or WAIT SHALL abandon the access; a late mem_rvalid after reset SHALL cause no writeback.

Configuration
REQ-017 With RISCV32IMA_MISALIGN_CHK_EN defined, the stage SHALL have an extra output misalign_err (1 bit); a misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) SHALL issue no memory request, SHALL write back nothing, and SHALL pulse misalign_err for one cycle.
REQ-018 Without RISCV32IMA_MISALIGN_CHK_EN, the misalign_err port SHALL be absent and low address bits beyond the access size SHALL be ignored (access aligned down).

Structure
REQ-019 Opcode constants, func3 load/store encodings and the FSM state enum SHALL reside in the shared package riscv32ima_pkg.
REQ-020 Load lane extraction and extension SHALL be the combinational sub-module riscv32ima_load_align.

Verification
REQ-021 OP, dst=5, data=0x1234 -> next cycle wback_reg_wen=1, addr 5, data 0x1234; back-to-back ops at full throughput.
REQ-022 JAL, dst=1, data=0x104, target 0x200 -> wback_pc_wen=1 with wback_pc=0x200, and x1=0x104, in the same cycle; BRANCH with data[0]=0 -> no pulses.
REQ-023 SB addr 0x1003, data 0xAB, mem_ready delayed 3 cycles -> mem_wstrb=1000, mem_wdata[31:24]=0xAB, held stable, alu_ready=0 until release.
REQ-024 LB addr 0x2001, rdata 0x0000_8000 -> 0xFFFF_FF80; LHU addr 0x2002, rdata 0xBEEF_0000 -> 0x0000_BEEF.
REQ-025 Reset asserted in WAIT, then mem_rvalid pulse -> no writeback, alu_ready=1.
REQ-026 With the macro defined, LW addr 0x3002 -> misalign_err pulse, mem_valid stays 0, wback_reg_wen stays 0.
